// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared LSU definitions: op codes, funct3 constants, FSM states and helpers.
// Used by ysyx_23060332_lsu and ysyx_23060332_lsu_ext.
package ysyx_23060332_lsu_pkg;

    localparam int LSU_LAT_DEFAULT = 1;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } lsu_op_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    function automatic logic funct3_legal(input lsu_op_e op, input logic [2:0] funct3);
        case (op)
            OP_LOAD:  return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
            OP_STORE: return funct3 inside {F3_B, F3_H, F3_W};
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] store_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B:    return 8'h01;
            F3_H:    return 8'h03;
            F3_W:    return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

    // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_ext.sv
// Combinational load extender: selects lb/lbu/lh/lhu/lw extension of raw
// memory data that is already byte-aligned to the access address.
module ysyx_23060332_lsu_ext
    import ysyx_23060332_lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    funct3,
    input  logic [DW-1:0] raw,
    output logic [DW-1:0] data
);

    always_comb begin
        // NOTE: default first so every path assigns data and no latch is inferred.
        data = raw;
        case (funct3)
            F3_B:    data = {{(DW-8){raw[7]}}, raw[7:0]};
            F3_BU:   data = {{(DW-8){1'b0}}, raw[7:0]};
            F3_H:    data = {{(DW-16){raw[15]}}, raw[15:0]};
            F3_HU:   data = {{(DW-16){1'b0}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit between EXU/WBU and the data-memory model.
// Define YSYX_23060332_LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors.
module ysyx_23060332_lsu
    import ysyx_23060332_lsu_pkg::*;
#(
    parameter int LAT = LSU_LAT_DEFAULT,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    output logic          mem_wen,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic [DW-1:0] mem_rdata
);

    lsu_state_e    state, state_d;
    logic [3:0]    cnt;
    lsu_op_e       op_q;
    logic [2:0]    funct3_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] ext_data;

    lsu_op_e req_op_e;
    logic    accept;
    logic    req_legal;
    logic    req_mis;
    logic    req_mem;
    logic    busy_load;
    logic    busy_store;
    logic    last_busy;

    assign req_op_e  = lsu_op_e'(req_op);
    assign req_ready = rst && (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_legal = funct3_legal(req_op_e, req_funct3);

`ifdef YSYX_23060332_LSU_MISALIGN_TRAP_EN
    assign req_mis = req_legal && misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_mis = 1'b0;
`endif

    assign req_mem = req_legal && !req_mis;

    assign busy_load  = (state == ST_BUSY) && (op_q == OP_LOAD);
    assign busy_store = (state == ST_BUSY) && (op_q == OP_STORE);
    assign last_busy  = (state == ST_BUSY) && (cnt == 4'd0);

    assign mem_ren   = busy_load;
    assign mem_raddr = busy_load ? addr_q : '0;
    assign mem_wen   = busy_store && last_busy;
    assign mem_waddr = busy_store ? addr_q : '0;
    assign mem_wdata = busy_store ? wdata_q : '0;
    assign mem_wmask = mem_wen ? store_mask(funct3_q) : 8'h00;
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (accept)    state_d = req_mem ? ST_BUSY : ST_RESP;
            ST_BUSY: if (last_busy) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 4'd0;
            op_q      <= OP_NONE;
            funct3_q  <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            cnt       <= 4'(LAT);
            op_q      <= req_op_e;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            // op=none is a legal no-op; anything else that skips memory is an error.
            rsp_err   <= (req_op_e != OP_NONE) && !req_mem;
        end else if (state == ST_BUSY) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else if (op_q == OP_LOAD) begin
                rsp_rdata <= ext_data;
            end
        end
    end

    ysyx_23060332_lsu_ext #(
        .DW (DW)
    ) u_ext (
        .funct3 (funct3_q),
        .raw    (mem_rdata),
        .data   (ext_data)
    );

endmodule
